// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: issue-stage busy-bit scoreboard with RAW/WAW/capacity stalls and register file read-port sequencing
module regfile_scoreboard #(
  parameter int MAX_OUT = 8,
  parameter int CNT_W = 16
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic                           issue_valid,
  output logic                           issue_ready,
  input  logic [4:0]                     issue_rs1,
  input  logic [4:0]                     issue_rs2,
  input  logic                           rs1_used,
  input  logic                           rs2_used,
  input  logic [4:0]                     issue_rd,
  input  logic                           rd_write,
  input  logic                           wb_valid,
  input  logic [4:0]                     wb_rd,
  input  logic                           flush,
  output logic                           rf_read1,
  output logic                           rf_read2,
  output logic [4:0]                     rf_readaddr1,
  output logic [4:0]                     rf_readaddr2,
  output logic [31:0]                    busy_vec,
  output logic [$clog2(MAX_OUT+1)-1:0]   outstanding,
  output logic [CNT_W-1:0]               stall_cnt,
  output logic                           wb_err
);
  localparam int OW = $clog2(MAX_OUT + 1);
  logic [31:0] busy, clr, eff_busy, set_vec;
  logic wb_hit, hazard, cap_stall, accept, set;
  always_comb begin
    clr = wb_valid ? (32'd1 << wb_rd) : 32'd0;
    eff_busy = busy & ~clr;
    wb_hit = wb_valid & busy[wb_rd];
    hazard = (rs1_used & (issue_rs1 != 5'd0) & eff_busy[issue_rs1]) |
             (rs2_used & (issue_rs2 != 5'd0) & eff_busy[issue_rs2]) |
             (rd_write & (issue_rd != 5'd0) & eff_busy[issue_rd]);
    cap_stall = rd_write & (issue_rd != 5'd0) & ((outstanding - OW'(wb_hit)) == OW'(MAX_OUT));
    issue_ready = rstn & ~flush & ~hazard & ~cap_stall;
    accept = issue_valid & issue_ready;
    set = accept & rd_write & (issue_rd != 5'd0);
    set_vec = set ? (32'd1 << issue_rd) : 32'd0;
    rf_read1 = accept & rs1_used;
    rf_read2 = accept & rs2_used;
    rf_readaddr1 = issue_rs1;
    rf_readaddr2 = issue_rs2;
    busy_vec = busy;
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      busy <= '0;
      outstanding <= '0;
      stall_cnt <= '0;
      wb_err <= 1'b0;
    end else begin
      busy <= flush ? 32'd0 : (eff_busy | set_vec);
      outstanding <= flush ? '0 : outstanding + OW'(set) - OW'(wb_hit);
      wb_err <= wb_err | (wb_valid & (wb_rd != 5'd0) & ~busy[wb_rd] & ~flush);
      if (issue_valid & ~issue_ready & ~&stall_cnt)
        stall_cnt <= stall_cnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed self-checking bench for regfile_scoreboard
module tb_regfile_scoreboard;
  logic clk = 0, rstn = 0;
  logic issue_valid, issue_ready, rs1_used, rs2_used, rd_write, wb_valid, flush;
  logic rf_read1, rf_read2, wb_err;
  logic [4:0] issue_rs1, issue_rs2, issue_rd, wb_rd, rf_readaddr1, rf_readaddr2;
  logic [31:0] busy_vec;
  logic [3:0] outstanding, stall_cnt;
  int checks = 0, errors = 0;
  regfile_scoreboard #(.MAX_OUT(8), .CNT_W(4)) dut (
    .clk(clk), .rstn(rstn), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .issue_rd(issue_rd), .rd_write(rd_write), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .rf_read1(rf_read1), .rf_read2(rf_read2), .rf_readaddr1(rf_readaddr1), .rf_readaddr2(rf_readaddr2),
    .busy_vec(busy_vec), .outstanding(outstanding), .stall_cnt(stall_cnt), .wb_err(wb_err)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    issue_valid = 0; rs1_used = 0; rs2_used = 0; rd_write = 0;
    issue_rs1 = 0; issue_rs2 = 0; issue_rd = 0;
    wb_valid = 0; wb_rd = 0; flush = 0;
  endtask
  task automatic issue(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic w);
    issue_valid = 1; issue_rs1 = rs1; rs1_used = u1; issue_rs2 = rs2; rs2_used = u2;
    issue_rd = rd; rd_write = w;
  endtask
  task automatic wb(input logic [4:0] r);
    wb_valid = 1; wb_rd = r;
  endtask
  task automatic do_reset();
    idle();
    rstn = 0;
    issue(5'd1, 1, 5'd2, 1, 5'd3, 1);
    #1;
    check("ready_in_reset", issue_ready, 0);
    step();
    step();
    idle();
    rstn = 1;
  endtask
  initial begin
    idle();
    do_reset();
    check("rst_busy", busy_vec, 0);
    check("rst_out", outstanding, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_err", wb_err, 0);
    issue(5'd1, 1, 5'd2, 1, 5'd5, 1);
    #1;
    check("add_ready", issue_ready, 1);
    check("add_rd1", rf_read1, 1);
    check("add_rd2", rf_read2, 1);
    check("add_addr1", rf_readaddr1, 1);
    check("add_addr2", rf_readaddr2, 2);
    step();
    idle();
    check("add_busy", busy_vec, 32'h20);
    check("add_out", outstanding, 1);
    issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
    #1;
    check("raw_ready", issue_ready, 0);
    check("raw_rd1", rf_read1, 0);
    step();
    check("raw_stall1", stall_cnt, 1);
    step();
    check("raw_stall2", stall_cnt, 2);
    wb(5'd5);
    #1;
    check("raw_bypass_ready", issue_ready, 1);
    check("raw_bypass_rd1", rf_read1, 1);
    step();
    idle();
    check("raw_busy_clr", busy_vec, 0);
    check("raw_out", outstanding, 0);
    check("raw_stall_hold", stall_cnt, 2);
    check("raw_err", wb_err, 0);
    issue(5'd0, 0, 5'd0, 0, 5'd7, 1);
    step();
    check("waw_busy", busy_vec, 32'h80);
    #1;
    check("waw_ready", issue_ready, 0);
    step();
    check("waw_stall", stall_cnt, 3);
    wb(5'd7);
    #1;
    check("waw_setclr_ready", issue_ready, 1);
    step();
    idle();
    check("waw_setclr_busy", busy_vec, 32'h80);
    check("waw_setclr_out", outstanding, 1);
    check("waw_err", wb_err, 0);
    wb(5'd7);
    step();
    idle();
    check("waw_drain", busy_vec, 0);
    for (int i = 1; i <= 8; i++) begin
      issue(5'd0, 0, 5'd0, 0, 5'(i), 1);
      step();
    end
    idle();
    check("cap_busy", busy_vec, 32'h1FE);
    check("cap_out", outstanding, 8);
    issue(5'd0, 0, 5'd0, 0, 5'd9, 1);
    #1;
    check("cap_stall", issue_ready, 0);
    issue(5'd10, 1, 5'd0, 0, 5'd9, 0);
    #1;
    check("cap_nowrite_ready", issue_ready, 1);
    issue(5'd0, 0, 5'd0, 0, 5'd9, 1);
    wb(5'd3);
    #1;
    check("cap_wb_ready", issue_ready, 1);
    step();
    idle();
    check("cap_wb_busy", busy_vec, 32'h3F6);
    check("cap_wb_out", outstanding, 8);
    check("cap_stall_cnt", stall_cnt, 3);
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      issue(5'd0, 0, 5'd0, 0, 5'(i), 1);
      step();
    end
    idle();
    check("fl_pre_busy", busy_vec, 32'h1E);
    check("fl_pre_out", outstanding, 4);
    flush = 1;
    issue(5'd0, 0, 5'd0, 0, 5'd10, 1);
    #1;
    check("fl_ready", issue_ready, 0);
    step();
    idle();
    check("fl_busy", busy_vec, 0);
    check("fl_out", outstanding, 0);
    check("fl_stall", stall_cnt, 1);
    issue(5'd1, 1, 5'd0, 0, 5'd0, 0);
    wb(5'd4);
    #1;
    check("fl_post_ready", issue_ready, 1);
    step();
    idle();
    check("fl_err_set", wb_err, 1);
    check("fl_err_busy", busy_vec, 0);
    step();
    step();
    check("fl_err_sticky", wb_err, 1);
    do_reset();
    check("fl_err_rst", wb_err, 0);
    issue(5'd0, 1, 5'd0, 1, 5'd0, 1);
    #1;
    check("x0_ready", issue_ready, 1);
    step();
    idle();
    check("x0_busy", busy_vec, 0);
    check("x0_out", outstanding, 0);
    wb(5'd0);
    step();
    idle();
    check("x0_err", wb_err, 0);
    issue(5'd0, 0, 5'd0, 0, 5'd5, 1);
    step();
    issue(5'd5, 1, 5'd0, 0, 5'd0, 0);
    for (int i = 0; i < 20; i++) step();
    check("sat_15", stall_cnt, 15);
    step();
    step();
    check("sat_hold", stall_cnt, 15);
    check("sat_ready", issue_ready, 0);
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Issue-stage scoreboard and read-port sequencer for the 32-entry register file in the ID stage. It tracks which architectural registers have a write in flight, holds back instructions with RAW or WAW hazards, and drives the register file's read strobes and addresses only for accepted instructions. It sits between the decoder (issue side) and the register file / writeback path, and exposes a sticky error flag and a stall performance counter.

## Interface
Parameters:
- MAX_OUT, 8: maximum number of registers simultaneously marked busy (1..31).
- CNT_W, 16: width of the stall performance counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rstn  in  1  reset; synchronous, active-low.
- issue_valid  in  1  decoder presents an instruction.
- issue_ready  out  1  scoreboard accepts; transfer occurs when issue_valid & issue_ready.
- issue_rs1, issue_rs2  in  5  source register addresses.
- rs1_used, rs2_used  in  1  instruction actually reads rs1 / rs2.
- issue_rd  in  5  destination register address.
- rd_write  in  1  instruction writes issue_rd.
- wb_valid  in  1  writeback completes this cycle (same signal as register file write).
- wb_rd  in  5  writeback destination.
- flush  in  1  kill all in-flight writes (branch redirect).
- rf_read1, rf_read2  out  1  register file read strobes.
- rf_readaddr1, rf_readaddr2  out  5  register file read addresses.
- busy_vec  out  32  registered busy bits; bit 0 is always 0.
- outstanding  out  $clog2(MAX_OUT+1)  registered count of set busy bits.
- stall_cnt  out  CNT_W  saturating count of cycles with issue_valid & !issue_ready.
- wb_err  out  1  sticky: writeback to a non-busy register other than x0.

## Operation
- clr[r] = wb_valid & (wb_rd == r). This lets an instruction issue in the same cycle its producer writes back, because the register file forwards write data to a same-edge read.
- eff_busy[r] = busy[r] & !clr[r].
- Hazard, combinational, evaluated on the current inputs:
  - (rs1_used & rs1 != 0 & eff_busy[rs1]) | (rs2_used & rs2 != 0 & eff_busy[rs2]) | (rd_write & rd != 0 & eff_busy[rd]).
- Capacity stall: rd_write & rd != 0 & (outstanding − (wb clears a busy reg ? 1 : 0)) == MAX_OUT.
- issue_ready = rstn & !flush & !hazard & !capacity_stall.
- accept = issue_valid & issue_ready.
- Read port outputs:
  - rf_read1 = accept & rs1_used; rf_read2 = accept & rs2_used.
  - rf_readaddr1/2 = issue_rs1/2, passed through unconditionally.
- Busy update, in priority order:
  1. flush: busy cleared to 0 and outstanding set to 0; wb and issue are ignored that cycle.
  2. Clear busy[wb_rd] if wb_valid.
  3. Set busy[issue_rd] if accept & rd_write & rd != 0. The set wins over a same-register clear.
- outstanding tracks the popcount of busy exactly, updated incrementally as +1, −1, 0 or ±0 for a simultaneous set and clear.
- wb_err is set when wb_valid & wb_rd != 0 & !busy[wb_rd] & !flush. It is cleared only by reset.
- stall_cnt increments when issue_valid & !issue_ready & rstn, and saturates at all-ones.
- A write to x0 is never tracked, and a read of x0 never stalls.

## Timing
- Reset (rstn=0 at an edge) sets busy_vec=0, outstanding=0, stall_cnt=0 and wb_err=0.
- issue_ready is 0 throughout reset, and also while flush is high.
- issue_ready, rf_read1/2 and rf_readaddr1/2 are combinational, with zero latency from the inputs.
- The register file returns data one cycle after rf_readN.
- Accept at edge T: busy[rd] is visible on busy_vec and in the hazard logic from cycle T+1.
- Writeback at cycle T:
  - It unblocks dependents in cycle T through the bypass.
  - busy_vec drops at T+1.
- flush at cycle T: busy_vec=0 from T+1, and an issue in T+1 is evaluated against empty state.
- Reset asserted mid-operation discards all busy state. Writebacks that arrive after reset for pre-reset instructions set wb_err.

## Test plan
- Reset, then issue add x5←x1,x2 with wb idle.
  - Required: issue_ready=1, rf_read1=rf_read2=1, rf_readaddr1=1, rf_readaddr2=2.
  - Required next cycle: busy_vec=0x20, outstanding=1.
- RAW: with x5 busy, issue a read of x5.
  - Required: issue_ready=0 and stall_cnt increments every cycle.
  - Then wb_valid, wb_rd=5 in cycle T: issue_ready=1 in the same cycle T, and busy_vec bit 5 is 0 at T+1.
- WAW plus simultaneous set and clear: x7 busy; issue writes x7 while wb_rd=7 in the same cycle.
  - Required: accept; busy[7] stays 1; outstanding unchanged.
- Capacity: MAX_OUT=8; issue 8 writes to x1..x8.
  - Required: a ninth write to x9 stalls.
  - Required: a non-writing instruction is still accepted.
  - Required: a writeback of x3 in the same cycle lets the x9 write issue.
- flush with 4 busy registers and a concurrent issue.
  - Required: issue_ready=0 during flush; next cycle busy_vec=0 and outstanding=0.
  - Required: a subsequent wb_rd=4 sets wb_err=1, which stays 1 until rstn=0.
- stall_cnt saturation with CNT_W=4: hold a stall for 20 cycles.
  - Required: stall_cnt=15 and it holds there.
- x0 handling: a write to x0 or a read of x0 never sets busy and never stalls.
  - Required: wb_rd=0 does not set wb_err.
